// File: rtl/relm_fp_normalize.sv
// Three-stage post-normalise / round-to-nearest-even / pack stage for the FADD and FMUL mantissa and info words.
// Optional sticky exception flags (status_out, status_clr) exist only when RELM_FP_STATUS_EN is defined.
module relm_fp_normalize #(
    parameter int WD     = 32,
    parameter int STAGES = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WD-1:0] m_in,
    input  logic [WD-1:0] info_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WD-1:0] f_out
`ifdef RELM_FP_STATUS_EN
    ,
    output logic [3:0]    status_out,
    input  logic          status_clr
`endif
);

    logic s1_valid_reg, s2_valid_reg, s3_valid_reg;
    logic s1_ready, s2_ready, s3_ready;

    // Each stage may load when it is empty or its occupant moves on this cycle.
    assign s3_ready  = !s3_valid_reg || out_ready;
    assign s2_ready  = !s2_valid_reg || s3_ready;
    assign s1_ready  = !s1_valid_reg || s2_ready;
    assign in_ready  = s1_ready;
    assign out_valid = s3_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s3_valid_reg <= 1'b0;
        end else begin
            if (s1_ready) s1_valid_reg <= in_valid;
            if (s2_ready) s2_valid_reg <= s1_valid_reg;
            if (s3_ready) s3_valid_reg <= s2_valid_reg;
        end
    end

    // S1: classify and count leading zeros below the carry bit.
    logic [4:0]  lz_next;
    logic [31:0] s1_m_reg;
    logic [7:0]  s1_exp_reg;
    logic [4:0]  s1_lz_reg;
    logic        s1_sign_reg, s1_inf_reg, s1_zero_reg, s1_mzero_reg;

    // An all-zero mantissa saturates the count at 30; the result is forced later anyway.
    always_comb begin
        lz_next = 5'd30;
        for (int i = 0; i < 31; i++) begin
            if (m_in[i]) lz_next = 5'(30 - i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_m_reg     <= '0;
            s1_exp_reg   <= '0;
            s1_lz_reg    <= '0;
            s1_sign_reg  <= 1'b0;
            s1_inf_reg   <= 1'b0;
            s1_zero_reg  <= 1'b0;
            s1_mzero_reg <= 1'b0;
        end else if (in_valid && s1_ready) begin
            s1_m_reg     <= m_in;
            s1_exp_reg   <= info_in[30:23];
            s1_lz_reg    <= lz_next;
            s1_sign_reg  <= info_in[31];
            s1_inf_reg   <= info_in[22];
            s1_zero_reg  <= info_in[21];
            s1_mzero_reg <= (m_in == '0);
        end
    end

    // S2: normalise so the hidden one is dropped and guard/sticky line up.
    logic [30:0] shifted;
    logic [22:0] frac_next;
    logic        guard_next, sticky_next;
    logic [9:0]  e_next;

    always_comb begin
        shifted = s1_m_reg[30:0] << s1_lz_reg;
        if (s1_m_reg[31]) begin
            frac_next   = s1_m_reg[30:8];
            guard_next  = s1_m_reg[7];
            sticky_next = |s1_m_reg[6:0];
            e_next      = {2'b00, s1_exp_reg} + 10'd1;
        end else begin
            frac_next   = shifted[29:7];
            guard_next  = shifted[6];
            sticky_next = |shifted[5:0];
            e_next      = {2'b00, s1_exp_reg} - {5'd0, s1_lz_reg};
        end
    end

    logic [22:0] s2_frac_reg;
    logic [9:0]  s2_e_reg;
    logic        s2_guard_reg, s2_sticky_reg;
    logic        s2_sign_reg, s2_inf_reg, s2_zero_reg, s2_mzero_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_frac_reg   <= '0;
            s2_e_reg      <= '0;
            s2_guard_reg  <= 1'b0;
            s2_sticky_reg <= 1'b0;
            s2_sign_reg   <= 1'b0;
            s2_inf_reg    <= 1'b0;
            s2_zero_reg   <= 1'b0;
            s2_mzero_reg  <= 1'b0;
        end else if (s1_valid_reg && s2_ready) begin
            s2_frac_reg   <= frac_next;
            s2_e_reg      <= e_next;
            s2_guard_reg  <= guard_next;
            s2_sticky_reg <= sticky_next;
            s2_sign_reg   <= s1_sign_reg;
            s2_inf_reg    <= s1_inf_reg;
            s2_zero_reg   <= s1_zero_reg;
            s2_mzero_reg  <= s1_mzero_reg;
        end
    end

    // S3: round to nearest even, then resolve specials in priority order.
    logic        round_inc, frac_cout, nan, e_ovf, e_unf;
    logic [22:0] frac_r;
    logic [9:0]  e_r;
    logic [31:0] f_next;

    assign round_inc            = s2_guard_reg && (s2_sticky_reg || s2_frac_reg[0]);
    assign {frac_cout, frac_r}  = {1'b0, s2_frac_reg} + {23'd0, round_inc};
    assign e_r                  = s2_e_reg + {9'd0, frac_cout};
    assign nan                  = s2_inf_reg && s2_zero_reg;
    // e_r is a 10-bit two's complement value; bit 9 marks a negative exponent.
    assign e_ovf                = !e_r[9] && (e_r >= 10'd255);
    assign e_unf                = e_r[9] || (e_r == 10'd0);

    always_comb begin
        f_next = {s2_sign_reg, e_r[7:0], frac_r};
        if (nan) begin
            f_next = {s2_sign_reg, 8'hFF, 23'h400000};
        end else if (s2_inf_reg || e_ovf) begin
            f_next = {s2_sign_reg, 8'hFF, 23'h0};
        end else if (s2_zero_reg || e_unf) begin
            f_next = {s2_sign_reg, 31'h0};
        end else if (s2_mzero_reg) begin
            f_next = 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_out <= '0;
        end else if (s2_valid_reg && s3_ready) begin
            f_out <= f_next;
        end
    end

`ifdef RELM_FP_STATUS_EN
    logic [3:0] flags_next, s3_flags_reg, status_reg, status_next;
    logic       is_normal, out_fire;

    assign is_normal = !s2_inf_reg && !s2_zero_reg && !s2_mzero_reg && !e_ovf && !e_unf;
    assign out_fire  = s3_valid_reg && out_ready;

    always_comb begin
        flags_next    = 4'b0000;
        flags_next[3] = nan;
        flags_next[2] = !s2_inf_reg && !s2_mzero_reg && e_ovf;
        flags_next[1] = !s2_inf_reg && !s2_zero_reg && !s2_mzero_reg && e_unf;
        flags_next[0] = is_normal && (s2_guard_reg || s2_sticky_reg);
    end

    // A clear coinciding with a new event keeps that event's flags.
    for (genvar gi = 0; gi < 4; gi++) begin : g_status
        assign status_next[gi] = (status_reg[gi] && !status_clr) || (out_fire && s3_flags_reg[gi]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_flags_reg <= '0;
            status_reg   <= '0;
        end else begin
            if (s2_valid_reg && s3_ready) s3_flags_reg <= flags_next;
            status_reg <= status_next;
        end
    end

    assign status_out = status_reg;
`endif

    logic unused_bits;
    assign unused_bits = &{1'b0, info_in[20:0], shifted[30], STAGES[0]};

endmodule

// File: tb/tb_relm_fp_normalize.sv
// Bench for relm_fp_normalize: spec vector table, backpressure and reset sequences, and a randomized run
// checked against an arithmetic reference model; honours RELM_FP_STATUS_EN.
`timescale 1ns/1ps
module tb_relm_fp_normalize;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] m_in = '0;
    logic [31:0] info_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] f_out;
`ifdef RELM_FP_STATUS_EN
    logic [3:0]  status_out;
    logic        status_clr = 1'b0;
`endif

    relm_fp_normalize #(.WD(32), .STAGES(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m_in      (m_in),
        .info_in   (info_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f_out     (f_out)
`ifdef RELM_FP_STATUS_EN
        ,
        .status_out(status_out),
        .status_clr(status_clr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] f;
        logic [3:0]  fl;
    } exp_t;

    typedef struct {
        logic [31:0] m;
        logic [31:0] info;
        logic [31:0] f;
        logic [3:0]  fl;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          step_no = 0;
    int          n_out = 0;
    bit          chk_lat = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_f = '0;
    logic [3:0]  st_model = '0;
    exp_t        exp_q[$];
    int          acc_q[$];
    string       ctx = "init";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s/%s: got %08h expected %08h (step %0d)", ctx, name, act, req, step_no);
        end
    endtask

    function automatic logic [31:0] mk_info(input logic s, input logic [7:0] e, input logic inf, input logic zero);
        return {s, e, inf, zero, 21'h0};
    endfunction

    // Reference: locate the leading one, take 23 fraction bits below it, round on the remainder.
    function automatic void model(input logic [31:0] m, input logic [31:0] info,
                                  output logic [31:0] f, output logic [3:0] fl);
        logic        sign, inf, zero, half, rest;
        logic [63:0] y;
        logic [24:0] q;
        int          p, e;
        sign = info[31];
        inf  = info[22];
        zero = info[21];
        half = 1'b0;
        rest = 1'b0;
        q    = '0;
        if (m == 0) begin
            e = int'(info[30:23]) - 30;
        end else begin
            p = 31;
            while (!m[p]) p--;
            y = {m, 32'h0};
            if (p <= 23) y = y << (23 - p);
            else         y = y >> (p - 23);
            q    = {1'b0, y[55:32]};
            half = y[31];
            rest = |y[30:0];
            e    = int'(info[30:23]) + p - 30;
            if (half && (rest || q[0])) q = q + 1;
            if (q[24]) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        fl = 4'b0000;
        if (inf && zero) begin
            f = {sign, 8'hFF, 23'h400000};
            fl[3] = 1'b1;
        end else if (inf || e >= 255) begin
            f = {sign, 8'hFF, 23'h0};
            fl[2] = !inf && (m != 0);
        end else if (zero || e <= 0) begin
            f = {sign, 31'h0};
            fl[1] = !zero && (m != 0);
        end else if (m == 0) begin
            f = 32'h0;
        end else begin
            f = {sign, e[7:0], q[22:0]};
            fl[0] = half || rest;
        end
    endfunction

    // One clock: drive at the falling edge, sample 1ns later, account for the transfers at the next rising edge.
    task automatic step(input logic iv, input logic [31:0] m, input logic [31:0] info,
                        input logic ordy, input logic clr, input logic [31:0] ef, input logic [3:0] efl,
                        output logic accepted);
        exp_t       e;
        logic [3:0] fire_fl;
        @(negedge clk);
        in_valid  = iv;
        m_in      = m;
        info_in   = info;
        out_ready = ordy;
`ifdef RELM_FP_STATUS_EN
        status_clr = clr;
`endif
        #1;
        if (prev_stall) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_f", f_out, prev_f);
        end
`ifdef RELM_FP_STATUS_EN
        check("status", 32'(status_out), 32'(st_model));
`endif
        accepted = iv && in_ready;
        if (accepted) begin
            e.f  = ef;
            e.fl = efl;
            exp_q.push_back(e);
            acc_q.push_back(step_no);
        end
        fire_fl = 4'b0000;
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s/spurious_out: got %08h expected no output", ctx, f_out);
            end else begin
                e = exp_q.pop_front();
                check("f_out", f_out, e.f);
                if (chk_lat) check("latency", 32'(step_no - acc_q[0]), 32'd3);
                void'(acc_q.pop_front());
                fire_fl = e.fl;
            end
        end
        st_model   = (clr ? 4'b0000 : st_model) | fire_fl;
        prev_stall = out_valid && !out_ready;
        prev_f     = f_out;
        step_no++;
    endtask

    task automatic rand_input(output logic [31:0] m, output logic [31:0] info);
        int r;
        r = $urandom_range(0, 9);
        if (r == 0)      m = 32'h0;
        else if (r < 3)  m = $urandom;
        else             m = $urandom >> $urandom_range(0, 31);
        info = {1'($urandom), 8'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), 21'($urandom)};
        if ($urandom_range(0, 3) == 0) info[30:23] = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 8)) : 8'($urandom_range(247, 255));
    endtask

    vec_t        tab[13];
    logic        acc;
    logic [31:0] rm, ri, rf;
    logic [3:0]  rfl;
    logic [31:0] bp_m[5], bp_i[5], bp_f[5];
    logic [3:0]  bp_fl[5];

    initial begin
        tab[0]  = '{32'h80000000, mk_info(0, 8'h7F, 0, 0), 32'h40000000, 4'b0000};
        tab[1]  = '{32'h40000040, mk_info(0, 8'h7F, 0, 0), 32'h3F800000, 4'b0001};
        tab[2]  = '{32'h400000C0, mk_info(0, 8'h7F, 0, 0), 32'h3F800002, 4'b0001};
        tab[3]  = '{32'h00400000, mk_info(0, 8'h7F, 0, 0), 32'h3B800000, 4'b0000};
        tab[4]  = '{32'h00000000, mk_info(1, 8'h7F, 0, 0), 32'h00000000, 4'b0000};
        tab[5]  = '{32'h80000000, mk_info(0, 8'hFE, 0, 0), 32'h7F800000, 4'b0100};
        tab[6]  = '{32'h00400000, mk_info(0, 8'h01, 0, 0), 32'h00000000, 4'b0010};
        tab[7]  = '{32'h40000000, mk_info(1, 8'h00, 1, 1), 32'hFFC00000, 4'b1000};
        tab[8]  = '{32'h7FFFFFC0, mk_info(0, 8'h7F, 0, 0), 32'h40000000, 4'b0001};
        tab[9]  = '{32'h40000000, mk_info(0, 8'h10, 1, 0), 32'h7F800000, 4'b0000};
        tab[10] = '{32'h40000000, mk_info(1, 8'h10, 0, 1), 32'h80000000, 4'b0000};
        tab[11] = '{32'h40000000, mk_info(0, 8'h01, 0, 0), 32'h00800000, 4'b0000};
        tab[12] = '{32'h7FFFFF80, mk_info(0, 8'hFE, 0, 0), 32'h7F7FFFFF, 4'b0000};

        // Reset state
        ctx = "reset";
        #2;
        check("out_valid", 32'(out_valid), 32'd0);
        check("f_out", f_out, 32'h0);
`ifdef RELM_FP_STATUS_EN
        check("status", 32'(status_out), 32'h0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, one at a time, with flags cleared beforehand
        chk_lat = 1;
        foreach (tab[i]) begin
            ctx = $sformatf("tab%0d", i);
            step(0, '0, '0, 1, 1, '0, '0, acc);
            step(1, tab[i].m, tab[i].info, 1, 0, tab[i].f, tab[i].fl, acc);
            for (int k = 0; k < 20 && exp_q.size() != 0; k++) step(0, '0, '0, 1, 0, '0, '0, acc);
            if (exp_q.size() != 0) check("timeout", 32'(exp_q.size()), 32'd0);
            step(0, '0, '0, 1, 0, '0, '0, acc);
        end
        chk_lat = 0;

        // Backpressure: five back-to-back inputs against a six-cycle stall
        ctx = "bp";
        for (int i = 0; i < 5; i++) begin
            rand_input(bp_m[i], bp_i[i]);
            model(bp_m[i], bp_i[i], bp_f[i], bp_fl[i]);
        end
        begin
            int nacc, out0;
            nacc = 0;
            out0 = n_out;
            for (int c = 0; c < 6; c++) begin
                step(1, bp_m[nacc], bp_i[nacc], 0, 0, bp_f[nacc], bp_fl[nacc], acc);
                if (acc) nacc++;
            end
            check("accepted", 32'(nacc), 32'd3);
            check("in_ready", 32'(in_ready), 32'd0);
            for (int c = 0; c < 30 && (nacc < 5 || exp_q.size() != 0); c++) begin
                if (nacc < 5) begin
                    step(1, bp_m[nacc], bp_i[nacc], 1, 0, bp_f[nacc], bp_fl[nacc], acc);
                    if (acc) nacc++;
                end else begin
                    step(0, '0, '0, 1, 0, '0, '0, acc);
                end
            end
            check("emerged", 32'(n_out - out0), 32'd5);
        end

        // Randomized traffic with random backpressure and flag clears
        ctx = "rand";
        for (int c = 0; c < 600; c++) begin
            rand_input(rm, ri);
            model(rm, ri, rf, rfl);
            step(($urandom_range(0, 3) != 0), rm, ri, ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 15) == 0), rf, rfl, acc);
        end
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) step(0, '0, '0, 1, 0, '0, '0, acc);
        check("drain", 32'(exp_q.size()), 32'd0);

        // Reset with two results in flight
        ctx = "midreset";
        step(1, 32'h80000000, mk_info(0, 8'hFE, 0, 0), 0, 0, 32'h7F800000, 4'b0100, acc);
        step(1, 32'h400000C0, mk_info(0, 8'h7F, 0, 0), 0, 0, 32'h3F800002, 4'b0001, acc);
        step(0, '0, '0, 0, 0, '0, '0, acc);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("out_valid", 32'(out_valid), 32'd0);
`ifdef RELM_FP_STATUS_EN
        check("status", 32'(status_out), 32'h0);
`endif
        exp_q.delete();
        acc_q.delete();
        st_model   = '0;
        prev_stall = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) step(0, '0, '0, 1, 0, '0, '0, acc);
        check("no_stale", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
